// File: rtl/demux_stream_array.sv
// ============================================================================
// Module   : demux_stream_array
// Brief    : Registered 1:NUM_OUT vector-beat demux with ready/valid handshakes.
//            Supports DIRECT, BROADCAST and ROUND_ROBIN routing modes.
//            Optional statistics counters: DEMUX_STREAM_ARRAY_STATS_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_stream_array #(
    parameter int ARRAY_SIZE = 9,
    parameter int DATA_SIZE  = 8,
    parameter int NUM_OUT    = 4,
    localparam int SEL_W     = $clog2(NUM_OUT),
    localparam int W         = ARRAY_SIZE * DATA_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [W-1:0]           s_data,
    input  logic [SEL_W-1:0]       s_sel,
    input  logic [1:0]             s_mode,
    output logic [NUM_OUT-1:0]     m_valid,
    input  logic [NUM_OUT-1:0]     m_ready,
    output logic [NUM_OUT*W-1:0]   m_data,
    output logic [SEL_W-1:0]       rr_ptr,
    output logic                   sel_err
`ifdef DEMUX_STREAM_ARRAY_STATS_EN
    ,
    output logic [NUM_OUT*16-1:0]  beat_cnt,
    output logic [15:0]            drop_cnt,
    input  logic                   stats_clr
`endif
);

    localparam logic [1:0]       MODE_BCAST = 2'b01;
    localparam logic [1:0]       MODE_RR    = 2'b10;
    localparam logic [SEL_W:0]   NUM_OUT_C  = (SEL_W+1)'(NUM_OUT);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(NUM_OUT - 1);

    logic                 w_is_bcast;
    logic                 w_is_rr;
    logic                 w_is_direct;
    logic                 w_sel_bad;
    logic                 w_accept;
    logic [NUM_OUT-1:0]   w_tgt;
    logic [NUM_OUT-1:0]   w_free;
    logic [NUM_OUT-1:0]   w_load;
    logic [NUM_OUT-1:0]   m_valid_q, m_valid_d;
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 sel_err_q, sel_err_d;

    // The reserved mode code falls through to DIRECT routing.
    assign w_is_bcast  = (s_mode == MODE_BCAST);
    assign w_is_rr     = (s_mode == MODE_RR);
    assign w_is_direct = !w_is_bcast && !w_is_rr;
    assign w_sel_bad   = ({1'b0, s_sel} >= NUM_OUT_C);

    always_comb begin
        w_tgt = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            w_tgt[k] = w_is_bcast
                     || (w_is_rr     && (rr_ptr_q == SEL_W'(k)))
                     || (w_is_direct && (s_sel    == SEL_W'(k)));
        end
    end

    // An empty target set (bad select) is always ready, so the beat drops.
    assign w_free   = ~m_valid_q | m_ready;
    assign s_ready  = &(w_free | ~w_tgt);
    assign w_accept = s_valid && s_ready;
    assign w_load   = {NUM_OUT{w_accept}} & w_tgt;

    always_comb begin
        m_valid_d = w_load | (m_valid_q & ~m_ready);
        rr_ptr_d  = rr_ptr_q;
        if (w_accept && w_is_rr) begin
            rr_ptr_d = (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + 1'b1;
        end
        sel_err_d = w_accept && w_is_direct && w_sel_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= '0;
            rr_ptr_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
            logic [W-1:0] data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (w_load[k]) begin
                    data_q <= s_data;
                end
            end

            assign m_data[k*W +: W] = data_q;
        end
    endgenerate

    assign m_valid = m_valid_q;
    assign rr_ptr  = rr_ptr_q;
    assign sel_err = sel_err_q;

`ifdef DEMUX_STREAM_ARRAY_STATS_EN
    logic [15:0] drop_cnt_q;

    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_beat
            logic [15:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (stats_clr) begin
                    cnt_q <= '0;
                end else if (m_valid_q[k] && m_ready[k] && (cnt_q != 16'hFFFF)) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end

            assign beat_cnt[k*16 +: 16] = cnt_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (stats_clr) begin
            drop_cnt_q <= '0;
        end else if (sel_err_q && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire
